// File: rtl/debug_uart_tx_arbiter_pkg.sv
// Shared types and defaults for the debug UART transmit arbiter.
// Byte width, FIFO sizing, wait-timeout default and the arbiter state encoding.
package debug_uart_tx_arbiter_pkg;

    localparam int UART_W           = 8;
    localparam int CPU_FIFO_AW_DEF  = 4;
    localparam int WAIT_TIMEOUT_DEF = 65535;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OCD_WAIT = 2'd1,
        ST_OCD_HOLD = 2'd2,
        ST_CPU_WAIT = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              last;
        logic [UART_W-1:0] data;
    } ocd_byte_t;

endpackage

// File: rtl/debug_uart_tx_arbiter_fifo.sv
// Small synchronous FIFO buffering CPU console bytes.
// A push while full and a pop while empty are both ignored.
module debug_tx_fifo
    import debug_uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_W = UART_W,
    parameter int AW     = CPU_FIFO_AW_DEF
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage holds data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/debug_uart_tx_arbiter.sv
// Arbitrates the debug UART transmitter between OCD reply frames (priority,
// frame-atomic) and a FIFO-buffered CPU console stream.
module debug_uart_tx_arbiter
    import debug_uart_tx_arbiter_pkg::*;
#(
    parameter int CPU_FIFO_AW  = CPU_FIFO_AW_DEF,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 sel_ocd1_cpu0,
    input  logic                 ocd_tx_start,
    input  logic [UART_W-1:0]    ocd_tx_data,
    input  logic                 ocd_frame_last,
    output logic                 ocd_tx_done,
    input  logic                 cpu_tx_valid,
    input  logic [UART_W-1:0]    cpu_tx_data,
    output logic                 cpu_tx_ready,
    output logic [CPU_FIFO_AW:0] cpu_fifo_count,
    output logic                 uart_tx_start,
    output logic [UART_W-1:0]    uart_tx_data,
    input  logic                 uart_tx_done_pulse,
    output logic                 owner_ocd,
    output logic                 timeout_err,
    output logic                 ocd_overrun_err
);

    localparam int               TMR_W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WAIT_TIMEOUT - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    ocd_byte_t         slot;
    logic              slot_full;
    logic              inflight_last;
    logic [TMR_W-1:0]  tmr;
    logic              tmr_expired;
    logic              launch_ocd;
    logic              launch_cpu;
    logic              finish_ocd;
    logic              timeout_hit;
    logic              fifo_full;
    logic              fifo_empty;
    logic [UART_W-1:0] fifo_head;

    debug_tx_fifo #(
        .DATA_W (UART_W),
        .AW     (CPU_FIFO_AW)
    ) u_cpu_fifo (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (cpu_tx_valid),
        .push_data  (cpu_tx_data),
        .pop        (launch_cpu),
        .head       (fifo_head),
        .count      (cpu_fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign cpu_tx_ready = ~fifo_full;
    assign owner_ocd    = (state == ST_OCD_WAIT) || (state == ST_OCD_HOLD);
    assign tmr_expired  = (tmr == TMR_LAST);

    always_comb begin
        state_next  = state;
        launch_ocd  = 1'b0;
        launch_cpu  = 1'b0;
        finish_ocd  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (slot_full) begin
                    launch_ocd = 1'b1;
                    state_next = ST_OCD_WAIT;
                end else if (!fifo_empty && !sel_ocd1_cpu0) begin
                    launch_cpu = 1'b1;
                    state_next = ST_CPU_WAIT;
                end
            end
            ST_OCD_WAIT: begin
                if (uart_tx_done_pulse) begin
                    finish_ocd = 1'b1;
                    state_next = inflight_last ? ST_IDLE : ST_OCD_HOLD;
                end else if (tmr_expired) begin
                    // Still acknowledge the byte so debug_reply is not left waiting.
                    finish_ocd  = 1'b1;
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_OCD_HOLD: begin
                if (slot_full) begin
                    launch_ocd = 1'b1;
                    state_next = ST_OCD_WAIT;
                end else if (tmr_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_CPU_WAIT: begin
                if (uart_tx_done_pulse) begin
                    state_next = ST_IDLE;
                end else if (tmr_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state           <= ST_IDLE;
            tmr             <= '0;
            slot_full       <= 1'b0;
            inflight_last   <= 1'b0;
            uart_tx_start   <= 1'b0;
            uart_tx_data    <= '0;
            ocd_tx_done     <= 1'b0;
            timeout_err     <= 1'b0;
            ocd_overrun_err <= 1'b0;
        end else begin
            state         <= state_next;
            uart_tx_start <= launch_ocd | launch_cpu;
            ocd_tx_done   <= finish_ocd;
            timeout_err   <= timeout_err | timeout_hit;

            if (state_next != state) tmr <= '0;
            else if (state != ST_IDLE) tmr <= tmr + TMR_W'(1);

            if (launch_ocd) begin
                uart_tx_data  <= slot.data;
                inflight_last <= slot.last;
            end else if (launch_cpu) begin
                uart_tx_data <= fifo_head;
            end

            // An arrival into an occupied slot is dropped even if the slot drains this cycle.
            if (launch_ocd) slot_full <= 1'b0;
            if (ocd_tx_start) begin
                if (slot_full) ocd_overrun_err <= 1'b1;
                else           slot_full       <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ocd_tx_start && !slot_full) slot <= '{last: ocd_frame_last, data: ocd_tx_data};
    end

endmodule
